eda_neigh_stack: RTL and testbench
==================================

Name: eda_neigh_stack

Overview:
- Consumer end of the comparator's neighbour-push interface for the regional-max flood fill.
- Accepts an 8-bit push mask plus the 8 neighbour addresses, and serialises the flagged addresses into an internal LIFO at one per cycle.
- Returns stack entries to the traversal controller through a registered pop interface.
- Tracks stack occupancy and reports overflow.

Parameters:
- M, 8, image rows; informational only; sets the default ADDR_WIDTH.
- N, 8, image columns; informational only.
- WINDOW_WIDTH, 9, pixels in the 3x3 window; neighbour count is WINDOW_WIDTH-1.
- ADDR_WIDTH, 6, pixel address width (clog2(M*N)).
- STACK_DEPTH, 64, number of LIFO entries; power of two, at least 2.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous flush of stack, state and overflow flag.
- push_valid  input  1  push_positions and neigh_addrs are valid this cycle.
- push_ready  output  1  block can accept a new mask.
- push_positions  input  WINDOW_WIDTH-1  bit i set means neighbour i is pushed.
- neigh_addrs  input  (WINDOW_WIDTH-1)*ADDR_WIDTH  neighbour i address in bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- pop_req  input  1  request to pop the top entry.
- pop_valid  output  1  pop_addr holds a popped entry; one-cycle pulse.
- pop_addr  output  ADDR_WIDTH  popped address.
- stack_empty  output  1  count == 0.
- stack_full  output  1  count == STACK_DEPTH.
- stack_count  output  clog2(STACK_DEPTH)+1  current occupancy.
- overflow  output  1  sticky; an entry was dropped because the stack was full.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state IDLE, count 0.
  - push_ready 1, pop_valid 0, pop_addr 0, overflow 0.
  - stack_empty 1, stack_full 0.
- FSM states: IDLE and PUSH. push_ready = (state == IDLE) and not clear.
- IDLE:
  - On push_valid && push_ready, register the mask and all addresses.
  - Mask != 0: go to PUSH.
  - Mask == 0: stay IDLE; this is a consumed no-op.
- PUSH:
  - Each cycle, write the address of the lowest-index set mask bit to the stack, then clear that bit.
  - When the last bit is cleared, return to IDLE; push_ready rises the following cycle.
  - A mask with k bits set takes exactly k cycles in PUSH. Addresses are written in ascending index order, so the highest index is popped first.
- Push while full:
  - If the stack is full and no pop occurs in the same cycle, the write is dropped.
  - overflow sets and stays set until reset or clear.
  - The mask bit is still cleared; the FSM does not stall.
- Pop:
  - pop_req with count > 0: pop_addr is loaded with the entry at count-1 and pop_valid is 1 on the next cycle.
  - pop_req with count == 0, or not asserted: pop_valid is 0 next cycle and pop_addr holds its last value.
- Simultaneous write and pop in the same cycle:
  - Pop returns the old top (pre-write).
  - The new entry is written into that same slot; count is unchanged; no overflow even when full.
- Simultaneous write and pop at count == 0: the write proceeds, the pop is ignored, count becomes 1.
- clear:
  - Highest priority over all other activity.
  - Next cycle: count 0, state IDLE, overflow 0, pop_valid 0.
  - An in-flight mask is discarded; the push_valid handshake in that cycle is not accepted.
- Timing and widths:
  - Outputs are registered except push_ready, stack_empty and stack_full, which are decoded from registers.
  - stack_count is one bit wider than the pointer so STACK_DEPTH is representable.
  - Addresses are stored and returned unmodified.
- Reset mid-PUSH: remaining bits are lost; all outputs return to reset values immediately.

Test Plan:
- Reset, then push_positions=8'b1000_0101 with addrs[i]=10+i: push_ready low for 3 cycles; count goes 1,2,3; three pops return 17, 12, 10 with pop_valid one cycle after each pop_req; stack_empty=1 at the end.
- Mask 8'h00 with push_valid: consumed in one cycle; push_ready stays 1; count stays 0; no state change.
- Fill to STACK_DEPTH, then push mask 8'h03: count stays 64; overflow=1 after the first dropped write; FSM returns to IDLE after 2 cycles; clear then sets overflow=0 and count=0.
- Stack holds {5,9} (top 9); push mask 8'h01 with addr 33 while pop_req is asserted in the write cycle: pop_addr=9; count stays 2; the next pop returns 33, then 5.
- pop_req on an empty stack: pop_valid stays 0 and pop_addr is unchanged. Assert reset_n=0 mid-PUSH with mask 8'hFF after 3 writes: immediately count=0, push_ready=1, pop_valid=0.

Source files
------------

// File: rtl/eda_neigh_stack_if.sv
`default_nettype none
// ============================================================================
// Module      : eda_neigh_stack_if
// Description : Neighbour-push and pop handshake bundle for eda_neigh_stack.
// Revision    : 1.0 - initial release
// ============================================================================
interface eda_neigh_stack_if #(
    parameter int WINDOW_WIDTH = 9,
    parameter int ADDR_WIDTH   = 6
);
    logic                                  push_valid;
    logic                                  push_ready;
    logic [WINDOW_WIDTH-2:0]               push_positions;
    logic [(WINDOW_WIDTH-1)*ADDR_WIDTH-1:0] neigh_addrs;
    logic                                  pop_req;
    logic                                  pop_valid;
    logic [ADDR_WIDTH-1:0]                 pop_addr;

    modport master (
        output push_valid, push_positions, neigh_addrs, pop_req,
        input  push_ready, pop_valid, pop_addr
    );

    modport slave (
        input  push_valid, push_positions, neigh_addrs, pop_req,
        output push_ready, pop_valid, pop_addr
    );
endinterface
`default_nettype wire

// File: rtl/eda_neigh_stack.sv
`default_nettype none
// ============================================================================
// Module      : eda_neigh_stack
// Description : Serialises flagged neighbour addresses into a LIFO, one per
//               cycle, and returns entries through a registered pop port.
// Revision    : 1.0 - initial release
// ============================================================================
module eda_neigh_stack #(
    parameter int M            = 8,
    parameter int N            = 8,
    parameter int WINDOW_WIDTH = 9,
    parameter int ADDR_WIDTH   = $clog2(M*N),
    parameter int STACK_DEPTH  = 64
) (
    input  wire logic                       clk,
    input  wire logic                       reset_n,
    input  wire logic                       clear,
    eda_neigh_stack_if.slave                bus,
    output logic                            stack_empty,
    output logic                            stack_full,
    output logic [$clog2(STACK_DEPTH):0]    stack_count,
    output logic                            overflow
);
    localparam int c_NB = WINDOW_WIDTH - 1;
    localparam int c_PW = $clog2(STACK_DEPTH);
    localparam int c_CW = c_PW + 1;
    localparam logic [c_CW-1:0] c_FULL     = c_CW'(STACK_DEPTH);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);
    localparam logic [c_PW-1:0] c_PTR_ONE  = c_PW'(1);
    localparam logic [c_NB-1:0] c_MASK_ONE = c_NB'(1);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_PUSH = 1'b1;

    logic [0:0]                   r_state;
    logic [0:0]                   w_next_state;
    logic [c_NB-1:0]              r_mask;
    logic [c_NB*ADDR_WIDTH-1:0]   r_addrs;
    logic [c_CW-1:0]              r_count;
    logic                         r_overflow;
    logic                         r_pop_valid;
    logic [ADDR_WIDTH-1:0]        r_pop_addr;
    logic [ADDR_WIDTH-1:0]        r_mem [STACK_DEPTH];

    logic                         w_push_ready;
    logic                         w_accept;
    logic                         w_write;
    logic                         w_pop;
    logic                         w_mem_we;
    logic [c_NB-1:0]              w_mask_next;
    logic [ADDR_WIDTH-1:0]        w_wr_addr;
    logic [c_PW-1:0]              w_top;
    logic [c_PW-1:0]              w_wr_ptr;

    assign stack_empty = (r_count == '0);
    assign stack_full  = (r_count == c_FULL);
    assign stack_count = r_count;
    assign overflow    = r_overflow;

    assign bus.push_ready = w_push_ready;
    assign bus.pop_valid  = r_pop_valid;
    assign bus.pop_addr   = r_pop_addr;

    assign w_accept    = bus.push_valid && w_push_ready;
    assign w_write     = (r_state == c_PUSH);
    assign w_pop       = bus.pop_req && !stack_empty;
    assign w_mask_next = r_mask & (r_mask - c_MASK_ONE);
    assign w_top       = r_count[c_PW-1:0] - c_PTR_ONE;
    // A simultaneous pop frees the top slot, so the new entry replaces it.
    assign w_wr_ptr    = w_pop ? w_top : r_count[c_PW-1:0];
    assign w_mem_we    = !clear && w_write && (w_pop || !stack_full);

    // Descending scan leaves the lowest-index set bit as the winner.
    always_comb begin
        w_wr_addr = '0;
        for (int i = c_NB - 1; i >= 0; i--) begin
            if (r_mask[i]) begin
                w_wr_addr = r_addrs[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (w_accept && (bus.push_positions != '0)) w_next_state = c_PUSH;
            c_PUSH:  if (w_mask_next == '0) w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
        if (clear) begin
            w_next_state = c_IDLE;
        end
    end

    always_comb begin
        w_push_ready = (r_state == c_IDLE) && !clear;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mask  <= '0;
            r_addrs <= '0;
        end else if (clear) begin
            r_mask  <= '0;
        end else if (w_accept) begin
            r_mask  <= bus.push_positions;
            r_addrs <= bus.neigh_addrs;
        end else if (w_write) begin
            r_mask  <= w_mask_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_pop_valid <= 1'b0;
            r_pop_addr  <= '0;
        end else if (clear) begin
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_pop_valid <= 1'b0;
        end else begin
            r_pop_valid <= w_pop;
            if (w_pop) begin
                r_pop_addr <= r_mem[w_top];
            end
            if (w_write && !w_pop) begin
                if (stack_full) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_count <= r_count + c_CNT_ONE;
                end
            end else if (w_pop && !w_write) begin
                r_count <= r_count - c_CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_wr_ptr] <= w_wr_addr;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_eda_neigh_stack.sv
`default_nettype none
// ============================================================================
// Module      : tb_eda_neigh_stack
// Description : Self-checking bench for eda_neigh_stack with a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eda_neigh_stack;
    localparam int c_AW    = 6;
    localparam int c_NB    = 8;
    localparam int c_DEPTH = 64;

    logic       clk;
    logic       reset_n;
    logic       clear;
    logic       stack_empty;
    logic       stack_full;
    logic [6:0] stack_count;
    logic       overflow;

    int total;
    int bad;

    eda_neigh_stack_if #(.WINDOW_WIDTH(9), .ADDR_WIDTH(c_AW)) bus ();

    eda_neigh_stack #(
        .M(8), .N(8), .WINDOW_WIDTH(9), .ADDR_WIDTH(c_AW), .STACK_DEPTH(c_DEPTH)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (clear),
        .bus         (bus),
        .stack_empty (stack_empty),
        .stack_full  (stack_full),
        .stack_count (stack_count),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: stack and pending-write list as plain queues.
    logic [c_AW-1:0] m_stk  [$];
    logic [c_AW-1:0] m_pend [$];
    bit              m_ovf;
    bit              m_pv;
    logic [c_AW-1:0] m_pa;

    typedef struct {
        bit        pv;
        logic [7:0] mask;
        bit        pop;
        bit        exp_ready;
        int        exp_count;
        bit        exp_pvalid;
        int        exp_paddr;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_stk.delete();
        m_pend.delete();
        m_ovf = 0;
        m_pv  = 0;
        m_pa  = '0;
    endtask

    task automatic model_step(input bit pv, input logic [7:0] mask,
                              input logic [47:0] addrs, input bit pr, input bit clr);
        bit ready;
        bit w;
        bit p;
        logic [c_AW-1:0] wa;
        ready = (m_pend.size() == 0) && !clr;
        if (clr) begin
            m_stk.delete();
            m_pend.delete();
            m_ovf = 0;
            m_pv  = 0;
            return;
        end
        w = (m_pend.size() > 0);
        p = pr && (m_stk.size() > 0);
        m_pv = p;
        if (p) m_pa = m_stk[$];
        if (w) begin
            wa = m_pend.pop_front();
            if (p) m_stk[m_stk.size()-1] = wa;
            else if (m_stk.size() < c_DEPTH) m_stk.push_back(wa);
            else m_ovf = 1;
        end else if (p) begin
            void'(m_stk.pop_back());
        end
        if (pv && ready) begin
            for (int i = 0; i < c_NB; i++)
                if (mask[i]) m_pend.push_back(addrs[i*c_AW +: c_AW]);
        end
    endtask

    task automatic check_regs();
        chk("count",    int'(stack_count),   m_stk.size());
        chk("empty",    int'(stack_empty),   int'(m_stk.size() == 0));
        chk("full",     int'(stack_full),    int'(m_stk.size() == c_DEPTH));
        chk("overflow", int'(overflow),      int'(m_ovf));
        chk("pop_valid", int'(bus.pop_valid), int'(m_pv));
        chk("pop_addr", int'(bus.pop_addr),  int'(m_pa));
    endtask

    // Called at posedge+1; returns at the next posedge+1.
    task automatic step(input bit pv, input logic [7:0] mask,
                        input logic [47:0] addrs, input bit pr, input bit clr);
        bus.push_valid     = pv;
        bus.push_positions = mask;
        bus.neigh_addrs    = addrs;
        bus.pop_req        = pr;
        clear              = clr;
        #2;
        chk("push_ready", int'(bus.push_ready), int'((m_pend.size() == 0) && !clr));
        @(posedge clk);
        model_step(pv, mask, addrs, pr, clr);
        #1;
        check_regs();
    endtask

    function automatic logic [47:0] rand_addrs();
        logic [47:0] a;
        for (int i = 0; i < c_NB; i++) a[i*c_AW +: c_AW] = c_AW'($urandom_range(0, 63));
        return a;
    endfunction

    logic [47:0] base_addrs;
    logic [47:0] a;
    vec_t        vecs [11];

    initial begin
        total = 0;
        bad   = 0;
        reset_n            = 1'b0;
        clear              = 1'b0;
        bus.push_valid     = 1'b0;
        bus.push_positions = '0;
        bus.neigh_addrs    = '0;
        bus.pop_req        = 1'b0;
        model_reset();
        for (int i = 0; i < c_NB; i++) base_addrs[i*c_AW +: c_AW] = c_AW'(10 + i);

        repeat (2) @(posedge clk);
        #1;
        check_regs();
        chk("reset_ready", int'(bus.push_ready), 1);
        reset_n = 1'b1;

        // Mask 1000_0101, addresses 10+i: writes 10,12,17; pops return 17,12,10.
        vecs[0]  = '{1, 8'h85, 0, 1, 0, 0, 0};
        vecs[1]  = '{0, 8'h00, 0, 0, 1, 0, 0};
        vecs[2]  = '{0, 8'h00, 0, 0, 2, 0, 0};
        vecs[3]  = '{0, 8'h00, 0, 0, 3, 0, 0};
        vecs[4]  = '{0, 8'h00, 1, 1, 2, 1, 17};
        vecs[5]  = '{0, 8'h00, 1, 1, 1, 1, 12};
        vecs[6]  = '{0, 8'h00, 1, 1, 0, 1, 10};
        vecs[7]  = '{0, 8'h00, 0, 1, 0, 0, 10};
        vecs[8]  = '{0, 8'h00, 1, 1, 0, 0, 10};
        vecs[9]  = '{1, 8'h00, 0, 1, 0, 0, 10};
        vecs[10] = '{0, 8'h00, 0, 1, 0, 0, 10};
        for (int v = 0; v < 11; v++) begin
            bus.push_valid     = vecs[v].pv;
            bus.push_positions = vecs[v].mask;
            bus.neigh_addrs    = base_addrs;
            bus.pop_req        = vecs[v].pop;
            clear              = 1'b0;
            #2;
            chk("tbl_ready", int'(bus.push_ready), int'(vecs[v].exp_ready));
            @(posedge clk);
            model_step(vecs[v].pv, vecs[v].mask, base_addrs, vecs[v].pop, 1'b0);
            #1;
            chk("tbl_count", int'(stack_count),   vecs[v].exp_count);
            chk("tbl_pvalid", int'(bus.pop_valid), int'(vecs[v].exp_pvalid));
            chk("tbl_paddr", int'(bus.pop_addr),  vecs[v].exp_paddr);
        end
        chk("tbl_empty", int'(stack_empty), 1);

        // Fill to depth, then a two-bit mask that must be dropped.
        for (int k = 0; k < 8; k++) begin
            step(1, 8'hFF, rand_addrs(), 0, 0);
            repeat (8) step(0, 8'h00, '0, 0, 0);
        end
        chk("fill_count", int'(stack_count), 64);
        chk("fill_full", int'(stack_full), 1);
        step(1, 8'h03, rand_addrs(), 0, 0);
        chk("ovf_before", int'(overflow), 0);
        step(0, 8'h00, '0, 0, 0);
        chk("ovf_first_drop", int'(overflow), 1);
        chk("ovf_count", int'(stack_count), 64);
        step(0, 8'h00, '0, 0, 0);
        chk("ovf_idle_ready", int'(bus.push_ready), 1);
        step(0, 8'h00, '0, 0, 1);
        chk("clr_ovf", int'(overflow), 0);
        chk("clr_count", int'(stack_count), 0);

        // Stack {5,9}, then write 33 while popping in the same cycle.
        a = '0; a[0 +: 6] = 6'd5; a[6 +: 6] = 6'd9;
        step(1, 8'h03, a, 0, 0);
        repeat (2) step(0, 8'h00, '0, 0, 0);
        a = '0; a[0 +: 6] = 6'd33;
        step(1, 8'h01, a, 0, 0);
        step(0, 8'h00, '0, 1, 0);
        chk("wp_addr", int'(bus.pop_addr), 9);
        chk("wp_count", int'(stack_count), 2);
        step(0, 8'h00, '0, 1, 0);
        chk("wp_pop33", int'(bus.pop_addr), 33);
        step(0, 8'h00, '0, 1, 0);
        chk("wp_pop5", int'(bus.pop_addr), 5);
        step(0, 8'h00, '0, 1, 0);
        chk("empty_pop_valid", int'(bus.pop_valid), 0);
        chk("empty_pop_addr", int'(bus.pop_addr), 5);

        // Asynchronous reset in the middle of an 8-entry push.
        step(1, 8'hFF, rand_addrs(), 0, 0);
        step(0, 8'h00, '0, 0, 0);
        step(0, 8'h00, '0, 0, 0);
        step(0, 8'h00, '0, 1, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_count", int'(stack_count), 0);
        chk("rst_ready", int'(bus.push_ready), 1);
        chk("rst_pvalid", int'(bus.pop_valid), 0);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        check_regs();

        // Randomised traffic against the queue model.
        for (int c = 0; c < 400; c++) begin
            step(bit'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), rand_addrs(),
                 bit'($urandom_range(0, 1)), ($urandom_range(0, 40) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
